// File: rtl/buff_serializer.sv
// buff_serializer: wide-to-narrow serializer with valid/ready back-pressure,
// selectable beat order, zero padding of a partial last beat and frame markers.
module buff_serializer #(
    parameter int DATA_BITS = 264,
    parameter int BITS      = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITS-1:0]      b_out,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy
);
    localparam int COUNT = (DATA_BITS + BITS - 1) / BITS;
    localparam int W     = COUNT * BITS;
    localparam int PAD   = W - DATA_BITS;
    localparam int CW    = COUNT > 1 ? $clog2(COUNT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    sr;
    logic [W-1:0]    padded;

    // Pad bits sit at the end of the word that is emitted last.
    assign padded    = MSB_FIRST ? W'(b_in) << PAD : W'(b_in);
    assign out_valid = state == SEND;
    assign busy      = state == SEND;
    assign b_out     = MSB_FIRST ? sr[W-1 -: BITS] : sr[BITS-1:0];
    assign out_first = out_valid & (cnt == '0);
    assign out_last  = out_valid & (cnt == CW'(COUNT - 1));
    assign in_ready  = !rst & ((state == IDLE) | (out_last & out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sr    <= padded;
                    cnt   <= '0;
                    state <= SEND;
                end
                SEND: if (out_ready) begin
                    if (out_last) begin
                        if (in_valid) begin
                            sr  <= padded;
                            cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        sr  <= MSB_FIRST ? sr << BITS : sr >> BITS;
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    sr    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_buff_serializer.sv
// tb_buff_serializer: randomized checks of buff_serializer against a beat-level
// reference model, for the default geometry and a padded 20-bit geometry.
module tb_buff_serializer;
    logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [263:0] b_in = '0;
    logic [19:0]  b_in20 = '0;
    logic         in_ready, out_valid, out_first, out_last, busy;
    logic [7:0]   b_out;
    logic         m_in_ready, m_out_valid, m_out_first, m_out_last, m_busy;
    logic [7:0]   m_b_out;
    logic         l_in_ready, l_out_valid, l_out_first, l_out_last, l_busy;
    logic [7:0]   l_b_out;
    int checks = 0, errors = 0;

    buff_serializer dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready), .b_out(b_out),
        .out_first(out_first), .out_last(out_last), .busy(busy));
    buff_serializer #(.DATA_BITS(20), .BITS(8), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(m_in_ready), .b_in(b_in20), .out_valid(m_out_valid),
        .out_ready(out_ready), .b_out(m_b_out), .out_first(m_out_first),
        .out_last(m_out_last), .busy(m_busy));
    buff_serializer #(.DATA_BITS(20), .BITS(8), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(l_in_ready), .b_in(b_in20), .out_valid(l_out_valid),
        .out_ready(out_ready), .b_out(l_b_out), .out_first(l_out_first),
        .out_last(l_out_last), .busy(l_busy));

    always #5 clk = ~clk;

    // Beat i of a d-bit word split into 8-bit beats, zero padded at the emitted-last end.
    function automatic logic [7:0] beat_ref(input logic [263:0] w, input int d, input bit msb,
                                            input int i);
        int count = (d + 7) / 8;
        int pad = count * 8 - d;
        if (msb) return 8'(({8'b0, w} << pad) >> (8 * (count - 1 - i)));
        return 8'(w >> (8 * i));
    endfunction

    function automatic logic [263:0] rand_word();
        logic [263:0] w = '0;
        for (int k = 0; k < 9; k++) w = {w[231:0], 32'($urandom)};
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        in_valid = 1;
        out_ready = 1;
        b_in = rand_word();
        step();
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, busy, b_out, out_first, out_last, in_ready} !== 13'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b busy=%b b_out=%h f=%b l=%b in_ready=%b required all 0",
                     out_valid, busy, b_out, out_first, out_last, in_ready);
        end
        step();
        rst = 0;
        in_valid = 0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b v=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
        step();
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            in_valid = 0;
            out_ready = 1'($urandom_range(0, 1));
            b_in = rand_word();
            b_in20 = 20'($urandom);
            @(negedge clk);
            checks++;
            if ({out_valid, m_out_valid, l_out_valid, busy} !== 4'b0) begin
                errors++;
                $display("FAIL idle_valid cycle %0d: got v=%b/%b/%b busy=%b required 0", i,
                         out_valid, m_out_valid, l_out_valid, busy);
            end
            checks++;
            if ({b_out, m_b_out, l_b_out} !== 24'b0) begin
                errors++;
                $display("FAIL idle_data cycle %0d: got %h %h %h required 0", i, b_out, m_b_out,
                         l_b_out);
            end
            step();
        end
    endtask

    task automatic test_known();
        logic [263:0] w;
        logic [10:0] exp;
        for (int k = 0; k < 33; k++) w[8 * (32 - k) +: 8] = 8'(k + 1);
        do_reset();
        b_in = w;
        in_valid = 1;
        out_ready = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            exp = {1'b1, 8'(i + 1), i == 0, i == 32};
            checks++;
            if ({out_valid, b_out, out_first, out_last} !== exp) begin
                errors++;
                $display("FAIL known_beat %0d: got %h required %h", i,
                         {out_valid, b_out, out_first, out_last}, exp);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL known_end: got v=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_pad();
        logic [19:0] w;
        logic [10:0] exp;
        for (int t = 0; t < 6; t++) begin
            w = t == 0 ? 20'hABCDE : 20'($urandom);
            do_reset();
            b_in20 = w;
            in_valid = 1;
            out_ready = 1;
            step();
            in_valid = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                exp = {1'b1, beat_ref({244'b0, w}, 20, 1, i), i == 0, i == 2};
                checks++;
                if ({m_out_valid, m_b_out, m_out_first, m_out_last} !== exp) begin
                    errors++;
                    $display("FAIL pad_msb word %h beat %0d: got %h required %h", w, i,
                             {m_out_valid, m_b_out, m_out_first, m_out_last}, exp);
                end
                exp = {1'b1, beat_ref({244'b0, w}, 20, 0, i), i == 0, i == 2};
                checks++;
                if ({l_out_valid, l_b_out, l_out_first, l_out_last} !== exp) begin
                    errors++;
                    $display("FAIL pad_lsb word %h beat %0d: got %h required %h", w, i,
                             {l_out_valid, l_b_out, l_out_first, l_out_last}, exp);
                end
                step();
            end
            @(negedge clk);
            checks++;
            if ({m_out_valid, l_out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL pad_end: got v=%b/%b required 0", m_out_valid, l_out_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [263:0] w = rand_word();
        logic [10:0] exp;
        int idx = 0, cyc = 0;
        do_reset();
        b_in = w;
        in_valid = 1;
        out_ready = 0;
        step();
        in_valid = 0;
        while (idx < 33 && cyc < 400) begin
            out_ready = cyc < 16 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            b_in = rand_word();
            @(negedge clk);
            exp = {1'b1, beat_ref(w, 264, 1, idx), idx == 0, idx == 32};
            checks++;
            if ({out_valid, b_out, out_first, out_last} !== exp) begin
                errors++;
                $display("FAIL stall_beat %0d cycle %0d: got %h required %h", idx, cyc,
                         {out_valid, b_out, out_first, out_last}, exp);
            end
            if (out_ready) idx++;
            cyc++;
            step();
        end
        checks++;
        if (idx !== 33) begin
            errors++;
            $display("FAIL stall_count: got %0d beats accepted required 33", idx);
        end
        out_ready = 1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: got v=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [263:0] wa = rand_word(), wb = rand_word();
        logic [11:0] exp;
        do_reset();
        b_in = wa;
        in_valid = 1;
        out_ready = 1;
        step();
        b_in = wb;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            exp = {1'b1, beat_ref(i < 33 ? wa : wb, 264, 1, i % 33), i % 33 == 0, i % 33 == 32,
                   i % 33 == 32};
            checks++;
            if ({out_valid, b_out, out_first, out_last, in_ready} !== exp) begin
                errors++;
                $display("FAIL b2b_beat %0d: got %h required %h", i,
                         {out_valid, b_out, out_first, out_last, in_ready}, exp);
            end
            step();
            if (i == 32) in_valid = 0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got v=%b required 0", out_valid);
        end
    endtask

    task automatic test_abort();
        logic [263:0] w = rand_word(), w2 = rand_word();
        logic [10:0] exp;
        do_reset();
        b_in = w;
        in_valid = 1;
        out_ready = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (b_out !== beat_ref(w, 264, 1, i)) begin
                errors++;
                $display("FAIL abort_pre beat %0d: got %h required %h", i, b_out,
                         beat_ref(w, 264, 1, i));
            end
            step();
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst_ready: got %b required 0", in_ready);
        end
        step();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL abort_after: got v=%b busy=%b in_ready=%b required 0 0 1", out_valid,
                     busy, in_ready);
        end
        b_in = w2;
        in_valid = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            exp = {1'b1, beat_ref(w2, 264, 1, i), i == 0, i == 32};
            checks++;
            if ({out_valid, b_out, out_first, out_last} !== exp) begin
                errors++;
                $display("FAIL abort_new beat %0d: got %h required %h", i,
                         {out_valid, b_out, out_first, out_last}, exp);
            end
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle();
        test_known();
        test_pad();
        test_stall();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
